mux2_arbiter: RTL and testbench
===============================

Name: mux2_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared WIDTH-bit 2:1 bus mux, driven by two requesters (port 0, port 1).
- Grants the bus to one requester for a whole packet (multi-beat, terminated by last), steers the mux select, and registers the selected beat into a single output stage with valid/ready flow control.
- Sits between the two datapath sources and the downstream consumer of the shared bus.

Parameters:
- WIDTH, 8, data bus width in bits.
- MAX_BEATS, 16, beat limit per grant; used only when ARB_BEAT_LIMIT_EN is defined; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in0_valid  input  1  requester 0 has a beat.
- in0_data  input  WIDTH  requester 0 beat data.
- in0_last  input  1  final beat of requester 0 packet.
- in0_ready  output  1  requester 0 beat accepted this cycle when in0_valid is also high.
- in1_valid  input  1  requester 1 has a beat.
- in1_data  input  WIDTH  requester 1 beat data.
- in1_last  input  1  final beat of requester 1 packet.
- in1_ready  output  1  requester 1 beat accepted this cycle when in1_valid is also high.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered beat.
- out_last  output  1  registered last flag.
- out_src  output  1  source port of the registered beat.
- out_ready  input  1  consumer accepts the beat when out_valid is also high.
- busy  output  1  high in GRANT0 or GRANT1.

Behaviour:
- Reset: state=IDLE, prio=0, out_valid=0, out_data=0, out_last=0, out_src=0, busy=0, in0_ready=in1_ready=0; beat counter=0. Reset wins over every other event, including mid-packet; any partial packet is abandoned and no sequencing is performed.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - Only in0_valid → GRANT0.
  - Only in1_valid → GRANT1.
  - Both valid → grant port equal to prio.
  - Neither → stay in IDLE.
  - Decision is registered, so there is one bubble cycle between IDLE and the first accepted beat.
- Mux select is 0 in GRANT0 and 1 in GRANT1. In IDLE it holds its last value.
- Readiness is combinational: space = !out_valid || out_ready.
  - in0_ready = (state==GRANT0) && space.
  - in1_ready = (state==GRANT1) && space.
  - The non-granted port's ready is always 0.
- Beat transfer when inX_valid && inX_ready. On the next edge out_data, out_last and out_src load the granted port's data, last and index, and out_valid goes to 1.
- Latency is 1 cycle from accept to out_valid. Sustained throughput is 1 beat/cycle while out_ready stays high.
- out_valid clears when out_ready && out_valid and no new beat loads in the same cycle. Simultaneous drain and load: the register takes the new beat and out_valid stays 1.
- Output stability: while out_valid && !out_ready, out_data, out_last and out_src hold stable.
- Transfer with last in GRANTx: next state is IDLE, prio becomes the other port (!x), beat counter clears.
- Requester drops valid mid-packet: the grant is held; no timeout unless the optional feature is compiled in.
- in1_valid while GRANT0 is active is ignored until the packet finishes. Fairness: with both ports continuously requesting, packets alternate 0,1,0,1…
- busy = (state != IDLE).

Optional Feature:
- Macro: ARB_BEAT_LIMIT_EN.
- Defined:
  - An 8-bit beat counter increments on each accepted beat in a GRANT state.
  - When the accepted beat is the MAX_BEATS-th beat and last=0, the arbiter forces IDLE, flips prio, and clears the counter.
  - That beat's out_last stays as sent (0).
  - The interrupted requester re-arbitrates later; its remaining beats continue as a new grant.
- Undefined: no counter; grant is held until last regardless of packet length.

Test Plan:
- Reset then idle, both valid=0 for 5 cycles → out_valid=0, busy=0, in0_ready=in1_ready=0 throughout.
- Single packet on port 0, beats 8'hA1, 8'hA2, 8'hA3(last), out_ready=1 → grant 1 cycle after valid; out_data A1, A2, A3 on 3 consecutive cycles, each 1 cycle after accept; out_last only on A3; out_src=0; then IDLE, prio=1.
- Both ports valid from reset, 2-beat packets each, repeated 3 times → out_src sequence 0,0,1,1,0,0,1,1,0,0,1,1; exactly one bubble cycle between packets.
- Backpressure: out_ready=0 for 4 cycles during port 1 packet 8'h10, 8'h11(last) → in1_ready=0 once out_valid=1; out_data holds 8'h10 stable; after out_ready=1, 8'h11 follows with no beat lost or duplicated.
- Reset asserted mid-packet after beat 2 of 4 on port 0 → next cycle out_valid=0, state IDLE, prio=0; a new packet on port 1 is granted normally afterwards.
- With ARB_BEAT_LIMIT_EN and MAX_BEATS=4: port 0 sends 6 beats while port 1 is waiting → 4 port-0 beats, then port 1's packet, then the remaining 2 port-0 beats. Without the macro → all 6 port-0 beats first.

Source files
------------

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin packet arbiter steering a shared 2:1 WIDTH-bit mux into one output register.
// Latency: one bubble cycle from IDLE to the first accepted beat; 1 cycle from accept to out_valid; 1 beat/cycle sustained.
// Backpressure: inX_ready = granted && (!out_valid || out_ready); a held output beat stays stable while out_ready is low.
// Optional: define ARB_BEAT_LIMIT_EN to end a grant after MAX_BEATS beats even without last.
module mux2_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           state;
  logic             prio;      // port that wins when both request in IDLE
  logic             sel;       // mux select; follows the grant, holds in IDLE
  logic             space;
  logic             accept;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;
  logic             limit_hit;

  // The output register can take a beat if it is empty or being drained this cycle.
  assign space     = !out_valid || out_ready;
  assign in0_ready = (state == GRANT0) && space;
  assign in1_ready = (state == GRANT1) && space;
  assign accept    = (in0_valid && in0_ready) || (in1_valid && in1_ready);
  assign mux_data  = sel ? in1_data : in0_data;
  assign mux_last  = sel ? in1_last : in0_last;
  assign busy      = (state != IDLE);

`ifdef ARB_BEAT_LIMIT_EN
  localparam logic [7:0] BEAT_LIMIT = 8'(MAX_BEATS);
  logic [7:0] beat_cnt;

  // Current beat is the last one this grant may carry.
  assign limit_hit = ((beat_cnt + 8'd1) == BEAT_LIMIT);
`else
  assign limit_hit = 1'b0;
`endif

  // Grant FSM: pick a port in IDLE, hold it until last (or the beat limit), then hand priority over.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prio  <= 1'b0;
      sel   <= 1'b0;
`ifdef ARB_BEAT_LIMIT_EN
      beat_cnt <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in0_valid && (!in1_valid || !prio)) begin
            state <= GRANT0;
            sel   <= 1'b0;
          end else if (in1_valid) begin
            state <= GRANT1;
            sel   <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (accept) begin
            if (mux_last || limit_hit) begin
              state <= IDLE;
              prio  <= !sel;
`ifdef ARB_BEAT_LIMIT_EN
              beat_cnt <= 8'd0;
`endif
            end else begin
`ifdef ARB_BEAT_LIMIT_EN
              beat_cnt <= beat_cnt + 8'd1;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: load on accept (even while draining), otherwise empty when the consumer takes the beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_last  <= mux_last;
      out_src   <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: directed scenarios plus randomized traffic against a packet-level reference model.
// Latency: not applicable (bench).
// Backpressure: out_ready driven directly in directed phases, randomly in the random phase.
module tb_mux2_arbiter;
  localparam int W  = 8;
  localparam int MB = 4;
`ifdef ARB_BEAT_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in0_valid, in0_last, in0_ready;
  logic         in1_valid, in1_last, in1_ready;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic         out_valid, out_last, out_src, out_ready, busy;

  always #5 clk = ~clk;

  mux2_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       s;
    int         c;
  } obs_t;

  beat_t q0[$];
  beat_t q1[$];
  obs_t  expq[$];
  obs_t  out_log[$];
  int    acc_log[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc0_cnt = 0;
  int vp0 = 100;
  int vp1 = 100;
  int rp = 100;
  bit rdy_rand = 1'b0;
  bit chk_en = 1'b0;

  // Reference model: who owns the bus, who has priority, what sits in the output register.
  int         own = -1;
  bit         mprio = 1'b0;
  bit         hv = 1'b0;
  logic [7:0] hd = 8'h00;
  bit         hl = 1'b0;
  bit         hs = 1'b0;
  int         bcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int port, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    if (port == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  task automatic push_pkt(input int port, input int len);
    for (int i = 0; i < len; i++) push(port, 8'($urandom), (i == len - 1));
  endtask

  task automatic wait_out(input int n, input int budget);
    int k = 0;
    while (out_log.size() < n && k < budget) begin
      step();
      k++;
    end
    total++;
    if (out_log.size() < n) begin
      bad++;
      $display("FAIL wait_out: got %0d beats expected %0d", out_log.size(), n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    step();
    reset = 1'b0;
  endtask

  // Sources present the head of their queue (with random gaps); output readiness optionally random.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (q0.size() > 0 && int'($urandom_range(99)) < vp0) begin
      in0_valid = 1'b1; in0_data = q0[0].d; in0_last = q0[0].l;
    end else begin
      in0_valid = 1'b0; in0_data = 8'($urandom); in0_last = 1'($urandom);
    end
    if (q1.size() > 0 && int'($urandom_range(99)) < vp1) begin
      in1_valid = 1'b1; in1_data = q1[0].d; in1_last = q1[0].l;
    end else begin
      in1_valid = 1'b0; in1_data = 8'($urandom); in1_last = 1'($urandom);
    end
    if (rdy_rand) out_ready = (int'($urandom_range(99)) < rp);
  end

  // Compare process: check every cycle, track handshakes, then advance the model one cycle.
  always @(negedge clk) begin
    bit   sp, er0, er1, a0, a1;
    obs_t o;
    sp  = !hv || out_ready;
    er0 = (own == 0) && sp;
    er1 = (own == 1) && sp;
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(own >= 0));
      chk("in0_ready", 32'(in0_ready), 32'(er0));
      chk("in1_ready", 32'(in1_ready), 32'(er1));
      chk("out_valid", 32'(out_valid), 32'(hv));
      chk("out_data", 32'(out_data), 32'(hd));
      chk("out_last", 32'(out_last), 32'(hl));
      chk("out_src", 32'(out_src), 32'(hs));
    end
    if (!reset) begin
      if (in0_valid && in0_ready) begin
        if (q0.size() > 0) void'(q0.pop_front());
        acc0_cnt++;
        acc_log.push_back(cyc);
        o.d = in0_data; o.l = in0_last; o.s = 1'b0; o.c = cyc;
        expq.push_back(o);
      end
      if (in1_valid && in1_ready) begin
        if (q1.size() > 0) void'(q1.pop_front());
        acc_log.push_back(cyc);
        o.d = in1_data; o.l = in1_last; o.s = 1'b1; o.c = cyc;
        expq.push_back(o);
      end
      if (out_valid && out_ready) begin
        o.d = out_data; o.l = out_last; o.s = out_src; o.c = cyc;
        out_log.push_back(o);
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got beat %0h with no accepted beat pending", out_data);
        end else begin
          chk("sb_data", 32'(out_data), 32'(expq[0].d));
          chk("sb_last", 32'(out_last), 32'(expq[0].l));
          chk("sb_src", 32'(out_src), 32'(expq[0].s));
          void'(expq.pop_front());
        end
      end
    end else begin
      expq.delete();
    end

    if (reset) begin
      own = -1; mprio = 1'b0; hv = 1'b0; hd = 8'h00; hl = 1'b0; hs = 1'b0; bcnt = 0;
    end else begin
      a0 = in0_valid && er0;
      a1 = in1_valid && er1;
      if (a0 || a1) begin
        hv = 1'b1;
        hd = a1 ? in1_data : in0_data;
        hl = a1 ? in1_last : in0_last;
        hs = a1;
      end else if (out_ready) begin
        hv = 1'b0;
      end
      if (own < 0) begin
        if (in0_valid && (!in1_valid || !mprio)) own = 0;
        else if (in1_valid) own = 1;
      end else if (a0 || a1) begin
        bcnt++;
        if (hl || (LIM && bcnt == MB)) begin
          mprio = !hs;
          own = -1;
          bcnt = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c0;
    logic [7:0] t2d[3];
    logic [7:0] t6d[8];
    logic       t6s[8];
    t2d = '{8'hA1, 8'hA2, 8'hA3};
`ifdef ARB_BEAT_LIMIT_EN
    t6d = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h70, 8'h71, 8'h64, 8'h65};
    t6s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`else
    t6d = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h70, 8'h71};
    t6s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
    reset = 1'b1;
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk_en = 1'b1;

    // Idle after reset.
    repeat (5) begin
      step();
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_in0_ready", 32'(in0_ready), 32'd0);
      chk("idle_in1_ready", 32'(in1_ready), 32'd0);
    end

    // Single three-beat packet on port 0.
    out_ready = 1'b1;
    out_log.delete();
    acc_log.delete();
    c0 = cyc;
    push(0, 8'hA1, 1'b0);
    push(0, 8'hA2, 1'b0);
    push(0, 8'hA3, 1'b1);
    wait_out(3, 40);
    if (out_log.size() >= 3) begin
      chk("t2_first_accept", 32'(acc_log[0]), 32'(c0 + 2));
      for (int i = 0; i < 3; i++) begin
        chk("t2_data", 32'(out_log[i].d), 32'(t2d[i]));
        chk("t2_last", 32'(out_log[i].l), 32'(i == 2));
        chk("t2_src", 32'(out_log[i].s), 32'd0);
        chk("t2_cycle", 32'(out_log[i].c), 32'(c0 + 3 + i));
      end
    end
    step();
    chk("t2_idle_busy", 32'(busy), 32'd0);

    // Both ports busy from reset: packets alternate with one bubble between.
    do_reset();
    out_log.delete();
    c0 = cyc;
    for (int p = 0; p < 3; p++) begin
      push(0, 8'(8'h20 + 2 * p), 1'b0);
      push(0, 8'(8'h21 + 2 * p), 1'b1);
      push(1, 8'(8'h30 + 2 * p), 1'b0);
      push(1, 8'(8'h31 + 2 * p), 1'b1);
    end
    wait_out(12, 100);
    if (out_log.size() >= 12) begin
      chk("t3_first_cycle", 32'(out_log[0].c), 32'(c0 + 3));
      for (int i = 0; i < 12; i++) begin
        chk("t3_src", 32'(out_log[i].s), 32'((i / 2) % 2));
        if (i > 0) chk("t3_gap", 32'(out_log[i].c - out_log[i-1].c), 32'((i % 2) ? 1 : 2));
      end
    end

    // Backpressure during a port 1 packet.
    out_ready = 1'b0;
    out_log.delete();
    push(1, 8'h10, 1'b0);
    push(1, 8'h11, 1'b1);
    repeat (2) step();
    repeat (4) begin
      step();
      chk("t4_out_valid", 32'(out_valid), 32'd1);
      chk("t4_out_data", 32'(out_data), 32'h10);
      chk("t4_out_src", 32'(out_src), 32'd1);
      chk("t4_in1_ready", 32'(in1_ready), 32'd0);
    end
    out_ready = 1'b1;
    wait_out(2, 20);
    repeat (3) step();
    chk("t4_count", 32'(out_log.size()), 32'd2);
    if (out_log.size() >= 2) begin
      chk("t4_data0", 32'(out_log[0].d), 32'h10);
      chk("t4_data1", 32'(out_log[1].d), 32'h11);
      chk("t4_last1", 32'(out_log[1].l), 32'd1);
    end

    // Reset in the middle of a port 0 packet.
    acc0_cnt = 0;
    push(0, 8'hB0, 1'b0);
    push(0, 8'hB1, 1'b0);
    for (int k = 0; k < 20 && acc0_cnt < 2; k++) step();
    step();
    chk("t5_grant_held", 32'(busy), 32'd1);
    do_reset();
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    out_log.delete();
    push(1, 8'hC0, 1'b0);
    push(1, 8'hC1, 1'b1);
    wait_out(2, 20);
    if (out_log.size() >= 2) begin
      chk("t5_src", 32'(out_log[0].s), 32'd1);
      chk("t5_data", 32'(out_log[1].d), 32'hC1);
    end

    // Long port 0 packet with port 1 waiting.
    do_reset();
    out_log.delete();
    for (int i = 0; i < 6; i++) push(0, 8'(8'h60 + i), (i == 5));
    push(1, 8'h70, 1'b0);
    push(1, 8'h71, 1'b1);
    wait_out(8, 60);
    if (out_log.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t6_data", 32'(out_log[i].d), 32'(t6d[i]));
        chk("t6_src", 32'(out_log[i].s), 32'(t6s[i]));
      end
    end

    // Randomized traffic with random gaps, backpressure and occasional reset.
    vp0 = 70; vp1 = 60; rp = 65;
    rdy_rand = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if (reset) reset = 1'b0;
      if (q0.size() < 3 && $urandom_range(3) == 0) push_pkt(0, int'($urandom_range(6, 1)));
      if (q1.size() < 3 && $urandom_range(3) == 0) push_pkt(1, int'($urandom_range(6, 1)));
      if ($urandom_range(499) == 0) begin
        reset = 1'b1;
        q0.delete();
        q1.delete();
      end
      step();
    end
    reset = 1'b0;
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    vp0 = 100; vp1 = 100;
    for (int k = 0; k < 500 && (q0.size() + q1.size() + expq.size()) > 0; k++) step();
    chk("drain_pending", 32'(q0.size() + q1.size() + expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
